apb_slave_regs: RTL and testbench
=================================

# apb_slave_regs

APB slave register bank sitting directly downstream of `apb_master`; it consumes the master's psel/penable/pwrite/paddr/pwdata and returns prdata/pready/pslverr. It holds `num_regs` word registers with a programmable wait-state count and decodes a base-address window. Out-of-range, misaligned and read-only-write accesses return an error. The register contents and per-register write strobes are exported to the rest of the SoC.

## Interface
- `addr_width`, 32, APB address width.
- `data_width`, 32, APB data and register width.
- `num_regs`, 8, number of word registers; power of two, ≥2.
- `base_addr`, 32'hA000_0000, byte address of register 0.
- `wait_cycles`, 0, wait states inserted in every access phase (0..15).
- `ro_mask`, 0, bit i = 1 makes register i read-only.
- `i_clk_apb`  in  1  APB clock; the block's only clock.
- `i_rstn_apb`  in  1  reset; asynchronous, active-low.
- `i_psel`  in  1  slave select.
- `i_penable`  in  1  access-phase enable.
- `i_pwrite`  in  1  1 = write, 0 = read.
- `i_paddr`  in  addr_width  byte address.
- `i_pwdata`  in  data_width  write data.
- `o_prdata`  out  data_width  read data, valid while o_pready = 1.
- `o_pready`  out  1  transfer complete.
- `o_pslverr`  out  1  error; only high together with o_pready.
- `o_regs`  out  num_regs*data_width  flattened contents, register i at bits [i*data_width +: data_width].
- `o_wr_pulse`  out  num_regs  one-cycle strobe after register i is written.

## Operation
- Decode: offset = i_paddr − base_addr. The access is legal when i_paddr[1:0] = 0 and base_addr ≤ i_paddr < base_addr + 4*num_regs. Index = offset[2 +: clog2(num_regs)].
- FSM states:
  - IDLE: when i_psel & !i_penable, latch address, direction, write data and the error flag; load wait counter with wait_cycles; go to ACCESS.
  - ACCESS: while cnt ≠ 0, decrement each cycle with o_pready = 0. When cnt = 0, o_pready = 1 (combinational from state and count) and return to IDLE at the next edge.
- Abort: if i_psel falls while in ACCESS, go to IDLE. There is no write and no pready.
- Error: illegal decode, or a write to an ro_mask register, gives o_pslverr = 1 with o_pready. Errored writes change nothing. Errored reads return o_prdata = 0.
- Write commit: at the edge where i_psel & i_penable & o_pready & !err, the register takes the latched wdata. o_wr_pulse[idx] is high for exactly the following cycle.
- Read: o_prdata is registered at the setup edge from the addressed register and held through ACCESS. It is 0 whenever not in ACCESS.
- A penable without a preceding setup, seen in IDLE, is ignored and no pready is produced.

## Timing
- Reset values:
  - all registers 0;
  - o_prdata 0, o_pready 0, o_pslverr 0, o_wr_pulse 0;
  - state IDLE, cnt 0.
- Latency:
  - With wait_cycles = 0, pready is high in the first access cycle, giving a 2-cycle transfer.
  - With wait_cycles = N, pready is high in access cycle N+1.
- Back-to-back: a setup in the cycle after completion is accepted. There are no dead cycles between transfers.
- Written data is visible on o_regs from the cycle after the commit edge. A read in the immediately following transfer returns the new value.
- Wait counter width is max(1, clog2(wait_cycles+1)). It never wraps, because it stops at 0.
- Reset asserted mid-transfer clears the state immediately. A pending write is lost and pready stays 0.

## Structure
- Shared package `apb_pkg`:
  - FSM state enum (IDLE, ACCESS);
  - constant APB_WORD_BYTES = 4;
  - decode helper function (legal/index).
- One natural sub-module, `apb_slave_decode`: combinational window, alignment and ro check, producing idx and err. The FSM, counter and register array stay in the top.

## Test plan
- Zero-wait write, then read: write 32'h12345678 to 32'hA000_0000, then read it back. Pready is high in the first access cycle of each transfer, o_wr_pulse[0] pulses once, and prdata = 32'h12345678 with pslverr = 0.
- wait_cycles = 2: write 32'hA2535614 to 32'hA000_0014. Pready is low for 2 access cycles and high on the 3rd, o_regs word 5 = 32'hA2535614, and o_wr_pulse[5] pulses.
- Out-of-range read of 32'hA100_0000 → pready = 1, pslverr = 1, prdata = 0. A misaligned write to 32'hA000_0002 → pslverr = 1 with no register change.
- ro_mask = 8'h01: write 32'hDEADBEEF to register 0 → pslverr = 1, register stays 0, no o_wr_pulse.
- psel dropped after 1 access cycle with wait_cycles = 3 → no write and no pready. A following valid transfer completes normally.
- Reset pulled low during the ACCESS wait → all outputs 0 immediately and registers cleared. A subsequent write completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: access FSM states, word size and the address window decode helper.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int unsigned APB_WORD_BYTES = 4;

  typedef struct packed {
    logic        legal;
    logic [31:0] index;
  } apb_dec_t;

  // Inputs are widened to 64 bits so base + window size can never overflow for a 32-bit bus.
  function automatic apb_dec_t apb_decode(input logic [63:0] addr, input logic [63:0] base,
                                          input int unsigned nregs);
    logic [63:0] off;
    apb_dec_t    dec;
    off       = addr - base;
    dec.legal = (addr >= base) && (off < 64'(nregs * APB_WORD_BYTES)) && (addr[1:0] == 2'b00);
    dec.index = off[33:2];
    return dec;
  endfunction

endpackage

// File: rtl/apb_slave_decode.sv
// Combinational address decode: window, alignment and read-only checks producing index and error.
module apb_slave_decode
  import apb_pkg::*;
#(
  parameter int unsigned            addr_width = 32,
  parameter int unsigned            num_regs   = 8,
  parameter logic [addr_width-1:0]  base_addr  = 'hA000_0000,
  parameter logic [num_regs-1:0]    ro_mask    = '0,
  localparam int unsigned           idx_width  = $clog2(num_regs)
) (
  input  logic [addr_width-1:0] i_paddr,
  input  logic                  i_pwrite,
  output logic [idx_width-1:0]  o_idx,
  output logic                  o_err
);

  apb_dec_t w_dec;
  logic     w_unused_idx_hi;

  always_comb begin
    w_dec = apb_decode(64'(i_paddr), 64'(base_addr), num_regs);
    o_idx = w_dec.index[idx_width-1:0];
    o_err = !w_dec.legal || (i_pwrite && ro_mask[o_idx]);
  end

  // Upper index bits are only meaningful for out-of-window addresses, which legal already rejects.
  assign w_unused_idx_hi = ^w_dec.index[31:idx_width];

endmodule

// File: rtl/apb_slave_regs.sv
// APB slave register bank: num_regs word registers, fixed wait states, error response
// on bad decode or read-only writes, contents and write strobes exported.
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int unsigned            addr_width  = 32,
  parameter int unsigned            data_width  = 32,
  parameter int unsigned            num_regs    = 8,
  parameter logic [addr_width-1:0]  base_addr   = 'hA000_0000,
  parameter int unsigned            wait_cycles = 0,
  parameter logic [num_regs-1:0]    ro_mask     = '0
) (
  input  logic                           i_clk_apb,
  input  logic                           i_rstn_apb,
  input  logic                           i_psel,
  input  logic                           i_penable,
  input  logic                           i_pwrite,
  input  logic [addr_width-1:0]          i_paddr,
  input  logic [data_width-1:0]          i_pwdata,
  output logic [data_width-1:0]          o_prdata,
  output logic                           o_pready,
  output logic                           o_pslverr,
  output logic [num_regs*data_width-1:0] o_regs,
  output logic [num_regs-1:0]            o_wr_pulse
);

  localparam int unsigned idx_width = $clog2(num_regs);
  localparam int unsigned cnt_width = ($clog2(wait_cycles + 1) > 1) ? $clog2(wait_cycles + 1) : 1;

  apb_state_e             r_state;
  logic [cnt_width-1:0]   r_cnt;
  logic [idx_width-1:0]   r_idx;
  logic                   r_write;
  logic                   r_err;
  logic [data_width-1:0]  r_wdata;
  logic [data_width-1:0]  r_prdata;
  logic [data_width-1:0]  r_regs [num_regs];
  logic [num_regs-1:0]    r_wr_pulse;

  logic [idx_width-1:0]   w_idx;
  logic                   w_err;
  logic                   w_pready;
  logic                   w_commit;

  apb_slave_decode #(
    .addr_width (addr_width),
    .num_regs   (num_regs),
    .base_addr  (base_addr),
    .ro_mask    (ro_mask)
  ) u_decode (
    .i_paddr  (i_paddr),
    .i_pwrite (i_pwrite),
    .o_idx    (w_idx),
    .o_err    (w_err)
  );

  // Gating with psel keeps an aborted transfer from ever showing pready.
  assign w_pready = (r_state == ACCESS) && (r_cnt == '0) && i_psel;
  assign w_commit = w_pready && i_penable && r_write && !r_err;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
    if (!i_rstn_apb) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_wdata  <= '0;
      r_prdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_psel && !i_penable) begin
            r_state  <= ACCESS;
            r_idx    <= w_idx;
            r_write  <= i_pwrite;
            r_err    <= w_err;
            r_wdata  <= i_pwdata;
            r_cnt    <= cnt_width'(wait_cycles);
            r_prdata <= (i_pwrite || w_err) ? '0 : r_regs[w_idx];
          end
        end
        ACCESS: begin
          if (!i_psel || (r_cnt == '0)) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_prdata <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: the register bank is reset word by word so o_regs is defined out of reset; it stays in flops.
  always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
    if (!i_rstn_apb) begin
      for (int unsigned i = 0; i < num_regs; i++) r_regs[i] <= '0;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit) begin
        r_regs[r_idx]     <= r_wdata;
        r_wr_pulse[r_idx] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < num_regs; g++) begin : g_regs_out
    assign o_regs[g*data_width +: data_width] = r_regs[g];
  end

  assign o_prdata   = r_prdata;
  assign o_pready   = w_pready;
  assign o_pslverr  = w_pready && r_err;
  assign o_wr_pulse = r_wr_pulse;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Self-checking bench for apb_slave_regs: three instances (0, 2 and 3 wait states, the last with
// register 0 read-only), a vector table with a scoreboard, and hand-written corner sequences.
module tb_apb_slave_regs;

  localparam int ND = 3;
  localparam int NR = 8;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NV = 15;

  typedef struct {
    int          d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        is_read;
    int          waits;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic             psel    [ND];
  logic             penable [ND];
  logic             pwrite  [ND];
  logic [AW-1:0]    paddr   [ND];
  logic [DW-1:0]    pwdata  [ND];
  logic [DW-1:0]    prdata  [ND];
  logic             pready  [ND];
  logic             pslverr [ND];
  logic [NR*DW-1:0] regs    [ND];
  logic [NR-1:0]    wr_pulse[ND];

  logic [DW-1:0] model [ND][NR];
  exp_t          sb[$];
  vec_t          vecs[NV];
  int            n_checks = 0;
  int            n_errors = 0;

  always #5 clk = ~clk;

  apb_slave_regs #(.wait_cycles(0), .ro_mask(8'h00)) u_dut0 (
    .i_clk_apb(clk), .i_rstn_apb(rst_n), .i_psel(psel[0]), .i_penable(penable[0]),
    .i_pwrite(pwrite[0]), .i_paddr(paddr[0]), .i_pwdata(pwdata[0]), .o_prdata(prdata[0]),
    .o_pready(pready[0]), .o_pslverr(pslverr[0]), .o_regs(regs[0]), .o_wr_pulse(wr_pulse[0]));

  apb_slave_regs #(.wait_cycles(2), .ro_mask(8'h00)) u_dut1 (
    .i_clk_apb(clk), .i_rstn_apb(rst_n), .i_psel(psel[1]), .i_penable(penable[1]),
    .i_pwrite(pwrite[1]), .i_paddr(paddr[1]), .i_pwdata(pwdata[1]), .o_prdata(prdata[1]),
    .o_pready(pready[1]), .o_pslverr(pslverr[1]), .o_regs(regs[1]), .o_wr_pulse(wr_pulse[1]));

  apb_slave_regs #(.wait_cycles(3), .ro_mask(8'h01)) u_dut2 (
    .i_clk_apb(clk), .i_rstn_apb(rst_n), .i_psel(psel[2]), .i_penable(penable[2]),
    .i_pwrite(pwrite[2]), .i_paddr(paddr[2]), .i_pwdata(pwdata[2]), .o_prdata(prdata[2]),
    .o_pready(pready[2]), .o_pslverr(pslverr[2]), .o_regs(regs[2]), .o_wr_pulse(wr_pulse[2]));

  function automatic int wait_of(input int d);
    case (d)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [NR*DW-1:0] packed_model(input int d);
    logic [NR*DW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = model[d][i];
    return r;
  endfunction

  task automatic check(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete transfer; returns after the cycle in which pready was sampled high.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic exp_err, input logic [31:0] exp_rd, input string name);
    exp_t e;
    int   w;
    logic done;
    e.err     = exp_err;
    e.rdata   = wr ? 32'h0 : exp_rd;
    e.is_read = !wr;
    e.waits   = wait_of(d);
    @(posedge clk); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wd;
    sb.push_back(e);
    @(posedge clk); #1;
    penable[d] = 1'b1;
    w = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (pready[d]) done = 1'b1;
      else begin
        w++;
        @(posedge clk); #1;
      end
    end
    check({name, "_pready_seen"}, done, 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (done) begin
        check({name, "_wait_cycles"}, w, e.waits);
        check({name, "_pslverr"}, pslverr[d], e.err);
        if (e.is_read) check({name, "_prdata"}, prdata[d], e.rdata);
        if (wr && !exp_err) model[d][addr[4:2]] = wd;
      end
    end
  endtask

  task automatic idle(input int d);
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  // Strobe must appear in the cycle after commit and be gone one cycle later.
  task automatic post_check(input int d, input logic committed, input logic [2:0] idx, input string name);
    logic [NR-1:0] exp_pulse;
    exp_pulse = committed ? (8'b1 << idx) : 8'b0;
    @(negedge clk);
    check({name, "_wr_pulse"}, wr_pulse[d], exp_pulse);
    check({name, "_regs"}, regs[d], packed_model(d));
    @(negedge clk);
    check({name, "_wr_pulse_end"}, wr_pulse[d], 0);
    check({name, "_prdata_idle"}, prdata[d], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic saw;
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
      for (int i = 0; i < NR; i++) model[d][i] = '0;
    end

    vecs[0]  = '{0, 1'b1, 32'hA000_0000, 32'h1234_5678, 1'b0, 32'h0};
    vecs[1]  = '{0, 1'b0, 32'hA000_0000, 32'h0,         1'b0, 32'h1234_5678};
    vecs[2]  = '{1, 1'b1, 32'hA000_0014, 32'hA253_5614, 1'b0, 32'h0};
    vecs[3]  = '{1, 1'b0, 32'hA000_0014, 32'h0,         1'b0, 32'hA253_5614};
    vecs[4]  = '{0, 1'b0, 32'hA100_0000, 32'h0,         1'b1, 32'h0};
    vecs[5]  = '{0, 1'b1, 32'hA000_0002, 32'h55AA_55AA, 1'b1, 32'h0};
    vecs[6]  = '{2, 1'b1, 32'hA000_0000, 32'hDEAD_BEEF, 1'b1, 32'h0};
    vecs[7]  = '{2, 1'b0, 32'hA000_0000, 32'h0,         1'b0, 32'h0};
    vecs[8]  = '{0, 1'b1, 32'hA000_001C, 32'hFFFF_0000, 1'b0, 32'h0};
    vecs[9]  = '{0, 1'b0, 32'hA000_001C, 32'h0,         1'b0, 32'hFFFF_0000};
    vecs[10] = '{0, 1'b0, 32'hA000_0020, 32'h0,         1'b1, 32'h0};
    vecs[11] = '{0, 1'b0, 32'h9FFF_FFFC, 32'h0,         1'b1, 32'h0};
    vecs[12] = '{0, 1'b0, 32'hA000_0014, 32'h0,         1'b0, 32'h0};
    vecs[13] = '{2, 1'b1, 32'hA000_0010, 32'h1111_2222, 1'b0, 32'h0};
    vecs[14] = '{2, 1'b1, 32'hA000_0023, 32'h7777_7777, 1'b1, 32'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("reset_pready%0d", d),   pready[d],   0);
      check($sformatf("reset_pslverr%0d", d),  pslverr[d],  0);
      check($sformatf("reset_prdata%0d", d),   prdata[d],   0);
      check($sformatf("reset_wr_pulse%0d", d), wr_pulse[d], 0);
      check($sformatf("reset_regs%0d", d),     regs[d],     0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      xfer(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].err, vecs[i].rd, $sformatf("v%0d", i));
      idle(vecs[i].d);
      post_check(vecs[i].d, vecs[i].wr && !vecs[i].err, vecs[i].addr[4:2], $sformatf("v%0d", i));
    end

    // Back-to-back: read setup in the cycle right after the write completes.
    xfer(0, 1'b1, 32'hA000_000C, 32'hCAFE_F00D, 1'b0, 32'h0, "b2b_wr");
    xfer(0, 1'b0, 32'hA000_000C, 32'h0, 1'b0, 32'hCAFE_F00D, "b2b_rd");
    idle(0);
    post_check(0, 1'b0, 3'd0, "b2b");

    // Stray penable in IDLE without a setup phase must be ignored.
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 32'hA000_0004; pwdata[0] = 32'h0BAD_0BAD;
    saw = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw = saw | pready[0];
    end
    check("stray_penable_pready", saw, 0);
    idle(0);
    post_check(0, 1'b0, 3'd0, "stray_penable");

    // Abort: psel drops after one access cycle with three wait states.
    @(posedge clk); #1;
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 32'hA000_000C; pwdata[2] = 32'h1357_9BDF;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    @(negedge clk);
    check("abort_pready_acc1", pready[2], 0);
    @(posedge clk); #1;
    psel[2] = 1'b0; penable[2] = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      saw = saw | pready[2] | (|wr_pulse[2]);
    end
    check("abort_no_pready_or_pulse", saw, 0);
    check("abort_regs", regs[2], packed_model(2));
    xfer(2, 1'b1, 32'hA000_000C, 32'h2468_ACE0, 1'b0, 32'h0, "after_abort");
    idle(2);
    post_check(2, 1'b1, 3'd3, "after_abort");

    // Reset asserted during the wait of a read of register 4.
    @(posedge clk); #1;
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b0; paddr[2] = 32'hA000_0010;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    @(negedge clk);
    check("rst_prdata_held", prdata[2], 32'h1111_2222);
    check("rst_pready_wait", pready[2], 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_pready",   pready[2],   0);
    check("rst_mid_pslverr",  pslverr[2],  0);
    check("rst_mid_prdata",   prdata[2],   0);
    check("rst_mid_wr_pulse", wr_pulse[2], 0);
    check("rst_mid_regs2",    regs[2],     0);
    check("rst_mid_regs0",    regs[0],     0);
    psel[2] = 1'b0; penable[2] = 1'b0;
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < NR; i++) model[d][i] = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    xfer(2, 1'b1, 32'hA000_0008, 32'h0F0F_0F0F, 1'b0, 32'h0, "post_rst_wr");
    idle(2);
    post_check(2, 1'b1, 3'd2, "post_rst");
    xfer(2, 1'b0, 32'hA000_0008, 32'h0, 1'b0, 32'h0F0F_0F0F, "post_rst_rd");
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
